// File: rtl/quotient_estimator_pkg.sv
// ---------------------------------------------------------------------------
// qe_pkg
// Shared types and width helpers for the quotient estimator.
//   qe_state_e  : controller states (IDLE, ISSUE, DRAIN, ROUND, DONE)
//   calc_acc_w  : width of the truncated product accumulator
//   calc_idx_w  : width of the limb index / multiplier tag
// ---------------------------------------------------------------------------
package qe_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } qe_state_e;

    // Accumulator holds (a_prime * m_prime) >> LIMB_W, which needs exactly this many bits.
    function automatic int calc_acc_w(input int limbs, input int limb_w, input int mul_w);
        return (limbs - 32'sd1) * limb_w + mul_w;
    endfunction

    function automatic int calc_idx_w(input int limbs);
        return $clog2(limbs + 32'sd1);
    endfunction

endpackage

// File: rtl/quotient_estimator_if.sv
// ---------------------------------------------------------------------------
// quotient_estimator_if
// Request/response bundle of the quotient estimator.
//   Request : in_valid, in_ready, a_prime, m_prime, if_last, round_en
//   Response: out_valid, out_ready, gamma
//   master  : the producer/consumer side (drives request, accepts gamma)
//   slave   : the estimator side
// ---------------------------------------------------------------------------
interface quotient_estimator_if #(
    parameter int LIMBS  = 2,
    parameter int LIMB_W = 80,
    parameter int MUL_W  = 80,
    parameter int RADIX  = 78
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LIMBS*LIMB_W-1:0]   a_prime;
    logic [MUL_W-1:0]          m_prime;
    logic                      if_last;
    logic                      round_en;
    logic                      out_valid;
    logic                      out_ready;
    logic [RADIX-1:0]          gamma;

    modport master (
        output in_valid, a_prime, m_prime, if_last, round_en, out_ready,
        input  in_ready, out_valid, gamma
    );

    modport slave (
        input  in_valid, a_prime, m_prime, if_last, round_en, out_ready,
        output in_ready, out_valid, gamma
    );
endinterface

// File: rtl/quotient_estimator_mul.sv
// ---------------------------------------------------------------------------
// limb_multiplier
// Unsigned LIMB_W x MUL_W multiplier with MUL_LAT register stages. A valid
// bit and a limb-index tag travel alongside the product so the consumer
// knows where to align it. rst empties the pipeline.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid_i      operand pair valid this cycle
//   in_tag_i        limb index of the operand pair
//   a_i, b_i        operands
//   out_valid_o     product valid (MUL_LAT cycles after in_valid_i)
//   out_tag_o       tag that accompanied the operands
//   p_o             full-width product
// ---------------------------------------------------------------------------
module limb_multiplier #(
    parameter int LIMB_W  = 80,
    parameter int MUL_W   = 80,
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid_i,
    input  logic [TAG_W-1:0]          in_tag_i,
    input  logic [LIMB_W-1:0]         a_i,
    input  logic [MUL_W-1:0]          b_i,
    output logic                      out_valid_o,
    output logic [TAG_W-1:0]          out_tag_o,
    output logic [LIMB_W+MUL_W-1:0]   p_o
);
    localparam int P_W = LIMB_W + MUL_W;

    logic [P_W-1:0]   prod_q [MUL_LAT];
    logic [TAG_W-1:0] tag_q  [MUL_LAT];
    logic [MUL_LAT-1:0] vld_q;

    // Stage 0 forms the product; later stages only delay it with its tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                prod_q[s] <= '0;
                tag_q[s]  <= '0;
            end
        end else begin
            vld_q[0]  <= in_valid_i;
            prod_q[0] <= P_W'(a_i) * P_W'(b_i);
            tag_q[0]  <= in_tag_i;
            for (int s = 1; s < MUL_LAT; s++) begin
                vld_q[s]  <= vld_q[s-1];
                prod_q[s] <= prod_q[s-1];
                tag_q[s]  <= tag_q[s-1];
            end
        end
    end

    assign out_valid_o = vld_q[MUL_LAT-1];
    assign out_tag_o   = tag_q[MUL_LAT-1];
    assign p_o         = prod_q[MUL_LAT-1];
endmodule

// File: rtl/quotient_estimator.sv
// ---------------------------------------------------------------------------
// quotient_estimator
// Barrett-style quotient digit estimator. Computes the truncated product
// ACC = (a_prime * m_prime) >> LIMB_W one limb per cycle through a shared
// pipelined multiplier, then extracts a RADIX-bit digit gamma with a
// mode-dependent shift and optional guarded +1 rounding.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous reset, active-high
//   bus   quotient_estimator_if.slave (request in, gamma out, valid/ready)
// Result appears LIMBS+MUL_LAT+2 cycles after the accepting edge's cycle.
// ---------------------------------------------------------------------------
module quotient_estimator
    import qe_pkg::*;
#(
    parameter int RADIX      = 78,
    parameter int LIMB_W     = 80,
    parameter int MUL_W      = 80,
    parameter int LIMBS      = 2,
    parameter int MUL_LAT    = 2,
    parameter int SHIFT_BASE = 72,
    parameter int SHIFT_ADJ  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    quotient_estimator_if.slave  bus
);
    localparam int ACC_W  = calc_acc_w(LIMBS, LIMB_W, MUL_W);
    localparam int IDX_W  = calc_idx_w(LIMBS);
    localparam int DRN_W  = $clog2(MUL_LAT + 1);
    localparam int P_W    = LIMB_W + MUL_W;
    localparam int S_LAST = SHIFT_BASE + SHIFT_ADJ;
    localparam int S_NORM = SHIFT_BASE - SHIFT_ADJ;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LIMBS - 1);
    localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'(MUL_LAT - 1);

    if (S_LAST >= ACC_W || SHIFT_ADJ >= RADIX) begin : g_bad_params
        $fatal(1, "quotient_estimator: shift range does not fit ACC_W/RADIX");
    end

    qe_state_e               state_q, state_d;
    logic [IDX_W-1:0]        limb_idx_q, limb_idx_d;
    logic [DRN_W-1:0]        drain_cnt_q, drain_cnt_d;
    logic [LIMBS*LIMB_W-1:0] a_q;
    logic [MUL_W-1:0]        m_q;
    logic                    if_last_q, round_en_q;
    logic [ACC_W-1:0]        acc_q;
    logic [RADIX-1:0]        gamma_q;
    logic                    out_valid_q;

    logic                    accept_s;
    logic                    issue_valid_s;
    logic [LIMB_W-1:0]       limb_s;
    logic                    mul_valid_s;
    logic [IDX_W-1:0]        mul_tag_s;
    logic [P_W-1:0]          mul_p_s;
    logic [ACC_W-1:0]        term_s;
    logic [RADIX-1:0]        g0_s;
    logic [RADIX:0]          g1_s;
    logic                    guard_s;
    logic [RADIX-1:0]        gamma_s;

    // in_ready is forced low while rst is asserted so nothing is accepted in the reset cycle.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign accept_s      = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.gamma     = gamma_q;
    assign limb_s        = a_q[int'(limb_idx_q) * LIMB_W +: LIMB_W];

    limb_multiplier #(
        .LIMB_W  (LIMB_W),
        .MUL_W   (MUL_W),
        .MUL_LAT (MUL_LAT),
        .TAG_W   (IDX_W)
    ) u_mul (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (issue_valid_s),
        .in_tag_i    (limb_idx_q),
        .a_i         (limb_s),
        .b_i         (m_q),
        .out_valid_o (mul_valid_s),
        .out_tag_o   (mul_tag_s),
        .p_o         (mul_p_s)
    );

    // Controller next-state: one limb issued per ISSUE cycle, then wait out the multiplier latency.
    always_comb begin
        state_d       = state_q;
        limb_idx_d    = limb_idx_q;
        drain_cnt_d   = drain_cnt_q;
        issue_valid_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d    = ISSUE;
                    limb_idx_d = '0;
                end else begin
                    state_d    = IDLE;
                end
            end
            ISSUE: begin
                issue_valid_s = 1'b1;
                if (limb_idx_q == LAST_IDX) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    limb_idx_d  = limb_idx_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt_q == LAST_DRN) begin
                    state_d     = ROUND;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRN_W'(1);
                end
            end
            ROUND: begin
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            limb_idx_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            limb_idx_q  <= limb_idx_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Operands are captured once at accept; the bus may change freely afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            m_q        <= '0;
            if_last_q  <= 1'b0;
            round_en_q <= 1'b0;
        end else if (accept_s) begin
            a_q        <= bus.a_prime;
            m_q        <= bus.m_prime;
            if_last_q  <= bus.if_last;
            round_en_q <= bus.round_en;
        end
    end

    // Align each partial product: limb 0 drops its low LIMB_W bits, limb i>=1 sits at (i-1)*LIMB_W.
    always_comb begin
        term_s = '0;
        if (mul_tag_s == '0) begin
            term_s = ACC_W'({{ACC_W{1'b0}}, mul_p_s} >> LIMB_W);
        end else begin
            term_s = ACC_W'({{ACC_W{1'b0}}, mul_p_s} << ((int'(mul_tag_s) - 32'sd1) * LIMB_W));
        end
    end

    // Accumulator: cleared on accept, summed modulo 2^ACC_W while a transaction is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (accept_s) begin
            acc_q <= '0;
        end else if (mul_valid_s && (state_q == ISSUE || state_q == DRAIN)) begin
            acc_q <= acc_q + term_s;
        end
    end

    // Digit extraction with guarded rounding; the guard stops +1 from carrying past the digit range.
    always_comb begin
        if (if_last_q) begin
            g0_s = RADIX'(acc_q >> S_LAST);
        end else begin
            g0_s = RADIX'(acc_q >> S_NORM);
        end
        g1_s = {1'b0, g0_s} + {{RADIX{1'b0}}, 1'b1};
        if (if_last_q) begin
            guard_s = g1_s[RADIX];
        end else begin
            guard_s = g1_s[RADIX-SHIFT_ADJ];
        end
        if (!round_en_q) begin
            gamma_s = g0_s;
        end else if (guard_s) begin
            gamma_s = g0_s;
        end else begin
            gamma_s = g1_s[RADIX-1:0];
        end
    end

    // Output register: loaded in ROUND, held through DONE until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            gamma_q     <= '0;
            out_valid_q <= 1'b0;
        end else if (state_q == ROUND) begin
            gamma_q     <= gamma_s;
            out_valid_q <= 1'b1;
        end else if (state_q == DONE && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule
